vram_port_arbiter: RTL and testbench

Sits between the CPU store queue and the single-port vector RAM (CPU window 0x2000–0x3FFF, 8 KiB). It drains queued CPU stores into VRAM and serves read requests from the vector generator on the same port. VG reads have priority, but writes are guaranteed forward progress. Stores that fall outside the VRAM window are popped, discarded and counted.

---
 rtl/vram_port_arbiter_if.sv | 28 ++
 rtl/vram_port_arbiter.sv | 139 +++++++++++++
 tb/tb_vram_port_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vram_port_arbiter_if.sv
// Store-queue, vector-generator and VRAM signals shared by the arbiter and its environment.
// master drives the queue head, VG request and RAM read data; slave is the arbiter side.
interface vram_port_arbiter_if;
    logic [7:0]  q_data;
    logic [15:0] q_addr;
    logic        q_valid;
    logic        q_empty;
    logic        q_can_write;
    logic        vg_req;
    logic [12:0] vg_addr;
    logic        vg_ack;
    logic [7:0]  vg_data;
    logic [12:0] ram_addr;
    logic [7:0]  ram_din;
    logic        ram_we;
    logic [7:0]  ram_dout;
    logic [7:0]  drop_count;

    modport master (
        output q_data, q_addr, q_valid, q_empty, vg_req, vg_addr, ram_dout,
        input  q_can_write, vg_ack, vg_data, ram_addr, ram_din, ram_we, drop_count
    );

    modport slave (
        input  q_data, q_addr, q_valid, q_empty, vg_req, vg_addr, ram_dout,
        output q_can_write, vg_ack, vg_data, ram_addr, ram_din, ram_we, drop_count
    );
endinterface

// File: rtl/vram_port_arbiter.sv
// Shares the single VRAM port between CPU store draining and vector-generator reads.
// Reads win, but a write burst is capped and every read is followed by a forced write.
module vram_port_arbiter #(
    parameter int unsigned BURST_MAX = 4,
    parameter logic [15:0] VRAM_BASE = 16'h2000
) (
    input logic                clk,
    input logic                rst_n,
    vram_port_arbiter_if.slave bus
);
    localparam int unsigned    BW        = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
    localparam logic [BW-1:0]  BURST_TOP = BW'(BURST_MAX - 1);

    typedef enum logic [2:0] {
        StIdle,
        StWrite,
        StRdAddr,
        StRdWait,
        StRdData
    } state_e;

    state_e      r_state;
    logic [BW-1:0] r_burst_cnt;
    logic [12:0] r_ram_addr;
    logic [7:0]  r_ram_din;
    logic        r_ram_we;
    logic        r_vg_ack;
    logic [7:0]  r_vg_data;
    logic [7:0]  r_drop_count;

    state_e      w_state_d;
    logic [BW-1:0] w_burst_d;
    logic [12:0] w_ram_addr_d;
    logic [7:0]  w_ram_din_d;
    logic        w_ram_we_d;
    logic        w_vg_ack_d;
    logic [7:0]  w_vg_data_d;
    logic [7:0]  w_drop_d;

    logic        w_accept;
    logic [15:0] w_off;
    logic        w_in_win;
    logic        w_burst_last;

    assign w_accept = (r_state == StWrite) && bus.q_valid && !bus.q_empty;
    assign w_off    = bus.q_addr - VRAM_BASE;
    assign w_in_win = w_off < 16'h2000;
    // Counter parks at BURST_MAX-1, so a read arriving late in a long burst waits one write.
    assign w_burst_last = (r_burst_cnt == BURST_TOP);

    always_comb begin
        w_state_d    = r_state;
        w_burst_d    = r_burst_cnt;
        w_ram_addr_d = r_ram_addr;
        w_ram_din_d  = r_ram_din;
        w_ram_we_d   = 1'b0;
        w_vg_ack_d   = 1'b0;
        w_vg_data_d  = r_vg_data;
        w_drop_d     = r_drop_count;

        unique case (r_state)
            StIdle: begin
                if (bus.vg_req) begin
                    w_state_d = StRdAddr;
                end else if (!bus.q_empty) begin
                    w_state_d = StWrite;
                end
            end
            StWrite: begin
                if (w_accept) begin
                    if (!w_burst_last) begin
                        w_burst_d = r_burst_cnt + BW'(1);
                    end
                    if (w_in_win) begin
                        w_ram_addr_d = w_off[12:0];
                        w_ram_din_d  = bus.q_data;
                        w_ram_we_d   = 1'b1;
                    end else if (r_drop_count != 8'hFF) begin
                        w_drop_d = r_drop_count + 8'd1;
                    end
                end
                // The last pop is only visible as q_empty one cycle later.
                if (w_accept && bus.vg_req && w_burst_last) begin
                    w_state_d = StRdAddr;
                    w_burst_d = '0;
                end else if (bus.q_empty) begin
                    w_state_d = StIdle;
                    w_burst_d = '0;
                end
            end
            StRdAddr: begin
                w_ram_addr_d = bus.vg_addr;
                w_state_d    = StRdWait;
            end
            StRdWait: begin
                w_state_d = StRdData;
            end
            StRdData: begin
                w_vg_data_d = bus.ram_dout;
                w_vg_ack_d  = 1'b1;
                w_state_d   = bus.q_empty ? StIdle : StWrite;
            end
            default: begin
                w_state_d = StIdle;
                w_burst_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= StIdle;
            r_burst_cnt  <= '0;
            r_ram_addr   <= '0;
            r_ram_din    <= '0;
            r_ram_we     <= 1'b0;
            r_vg_ack     <= 1'b0;
            r_vg_data    <= '0;
            r_drop_count <= '0;
        end else begin
            r_state      <= w_state_d;
            r_burst_cnt  <= w_burst_d;
            r_ram_addr   <= w_ram_addr_d;
            r_ram_din    <= w_ram_din_d;
            r_ram_we     <= w_ram_we_d;
            r_vg_ack     <= w_vg_ack_d;
            r_vg_data    <= w_vg_data_d;
            r_drop_count <= w_drop_d;
        end
    end

    assign bus.q_can_write = (r_state == StWrite);
    assign bus.ram_addr    = r_ram_addr;
    assign bus.ram_din     = r_ram_din;
    assign bus.ram_we      = r_ram_we;
    assign bus.vg_ack      = r_vg_ack;
    assign bus.vg_data     = r_vg_data;
    assign bus.drop_count  = r_drop_count;
endmodule

// File: tb/tb_vram_port_arbiter.sv
// Directed plus randomized bench for vram_port_arbiter with a queue, RAM and store model.
`timescale 1ns/1ps
module tb_vram_port_arbiter;
    localparam int unsigned BURST_MAX = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    vram_port_arbiter_if bus();

    vram_port_arbiter #(
        .BURST_MAX(BURST_MAX),
        .VRAM_BASE(16'h2000)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Store queue: bench pushes at the tail, pops follow q_can_write.
    logic [7:0]  qd [0:1023];
    logic [15:0] qa [0:1023];
    int q_head = 0;
    int q_tail = 0;

    assign bus.q_empty = (q_head == q_tail);
    assign bus.q_data  = qd[q_head[9:0]];
    assign bus.q_addr  = qa[q_head[9:0]];
    assign bus.q_valid = bus.q_can_write && !bus.q_empty;

    always @(posedge clk) begin
        if (bus.q_can_write && q_head != q_tail) q_head <= q_head + 1;
    end

    // Synchronous single-port RAM.
    logic [7:0] mem [0:8191];
    always @(posedge clk) begin
        if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
        bus.ram_dout <= mem[bus.ram_addr];
    end

    // Bus activity log.
    int  wr_log[$];
    byte ev_log[$];
    int  ack_cnt = 0;
    always @(posedge clk) begin
        if (bus.ram_we) begin
            wr_log.push_back(int'({bus.ram_addr, bus.ram_din}));
            ev_log.push_back("W");
        end
        if (bus.vg_ack) begin
            ack_cnt <= ack_cnt + 1;
            ev_log.push_back("R");
        end
    end

    // Reference model of what the stores should do to VRAM.
    int   exp_wr[$];
    int   wr_seen = 0;
    int   exp_drop = 0;
    logic [7:0] mdl_mem [0:8191];
    bit   mdl_known [0:8191];
    int   known_list[$];

    int n_checks = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] a, input logic [7:0] d);
        int off;
        qa[q_tail[9:0]] = a;
        qd[q_tail[9:0]] = d;
        q_tail = q_tail + 1;
        if (a >= 16'h2000 && a < 16'h4000) begin
            off = int'(a) - 'h2000;
            exp_wr.push_back(off * 256 + int'(d));
            mdl_mem[off] = d;
            if (!mdl_known[off]) begin
                mdl_known[off] = 1'b1;
                known_list.push_back(off);
            end
        end else if (exp_drop < 255) begin
            exp_drop++;
        end
    endtask

    task automatic drain(input string tag, input int bound);
        int n;
        n = 0;
        while ((q_head != q_tail || bus.q_can_write) && n < bound) begin
            tick();
            n++;
        end
        tick();
        tick();
        chk({tag, "_drained"}, 32'(q_head == q_tail && !bus.q_can_write), 32'd1);
    endtask

    task automatic check_writes(input string tag);
        chk({tag, "_wr_count"}, wr_log.size(), exp_wr.size());
        while (wr_seen < wr_log.size() && wr_seen < exp_wr.size()) begin
            chk({tag, "_wr"}, wr_log[wr_seen], exp_wr[wr_seen]);
            wr_seen++;
        end
        wr_seen = wr_log.size();
    endtask

    task automatic wait_ack(input string tag, input int bound);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.vg_ack && n < bound + 2);
        chk({tag, "_ack_in_time"}, 32'(bus.vg_ack && n <= bound), 32'd1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_q_can_write"}, bus.q_can_write, 0);
        chk({tag, "_vg_ack"}, bus.vg_ack, 0);
        chk({tag, "_vg_data"}, bus.vg_data, 0);
        chk({tag, "_ram_addr"}, bus.ram_addr, 0);
        chk({tag, "_ram_din"}, bus.ram_din, 0);
        chk({tag, "_ram_we"}, bus.ram_we, 0);
        chk({tag, "_drop_count"}, bus.drop_count, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wr0, ev0, ack0;
        string seq;
        bus.vg_req  = 1'b0;
        bus.vg_addr = '0;

        // Reset behaviour.
        #1 rst_n = 1'b0;
        #1 chk_all_zero("rst_async");
        repeat (3) @(posedge clk);
        #1 chk_all_zero("rst_held");
        #6 rst_n = 1'b1;
        repeat (20) tick();
        chk("idle_no_we", wr_log.size(), 0);
        chk("idle_q_can_write", bus.q_can_write, 0);

        // Single in-window store.
        push(16'h2345, 8'hA5);
        tick();
        chk("single_q_can_write", bus.q_can_write, 1);
        chk("single_we_not_yet", bus.ram_we, 0);
        tick();
        chk("single_we", bus.ram_we, 1);
        chk("single_addr", bus.ram_addr, 13'h0345);
        chk("single_din", bus.ram_din, 8'hA5);
        tick();
        chk("single_we_pulse", bus.ram_we, 0);
        chk("single_back_idle", bus.q_can_write, 0);
        chk("single_drop", bus.drop_count, 0);
        check_writes("single");

        // VG read from IDLE.
        push(16'h2100, 8'h3C);
        drain("preload", 50);
        check_writes("preload");
        wr0 = wr_log.size();
        bus.vg_addr = 13'h0100;
        bus.vg_req  = 1'b1;
        tick();
        chk("rd_c1_ack", bus.vg_ack, 0);
        tick();
        chk("rd_c2_ack", bus.vg_ack, 0);
        chk("rd_c2_addr", bus.ram_addr, 13'h0100);
        tick();
        chk("rd_c3_ack", bus.vg_ack, 0);
        tick();
        chk("rd_c4_ack", bus.vg_ack, 1);
        chk("rd_c4_data", bus.vg_data, 8'h3C);
        bus.vg_req = 1'b0;
        tick();
        chk("rd_ack_pulse", bus.vg_ack, 0);
        chk("rd_no_we", wr_log.size(), wr0);

        // Contention: 10 stores, read raised during the first write.
        ev0 = ev_log.size();
        for (int i = 0; i < 10; i++) push(16'h2400 + 16'(i * 'h37), 8'(8'hC0 + i));
        tick();
        chk("cont_first_write", bus.q_can_write, 1);
        bus.vg_addr = 13'h0100;
        bus.vg_req  = 1'b1;
        wait_ack("cont", 12);
        chk("cont_rd_data", bus.vg_data, 8'h3C);
        bus.vg_req = 1'b0;
        drain("cont", 60);
        check_writes("cont");
        seq = "WWWWRWWWWWW";
        chk("cont_ev_count", ev_log.size() - ev0, seq.len());
        for (int i = 0; i < seq.len() && ev0 + i < ev_log.size(); i++) begin
            chk($sformatf("cont_ev%0d", i), ev_log[ev0 + i], seq[i]);
        end

        // Out-of-window stores.
        wr0 = wr_log.size();
        push(16'h1FFF, 8'h11);
        push(16'h4000, 8'h22);
        push(16'h0000, 8'h33);
        drain("oow", 50);
        chk("oow_no_we", wr_log.size(), wr0);
        chk("oow_drop", bus.drop_count, exp_drop);

        // Async reset in RD_WAIT.
        bus.vg_addr = 13'h0345;
        bus.vg_req  = 1'b1;
        tick();
        tick();
        ack0 = ack_cnt;
        #2 rst_n = 1'b0;
        #1 chk_all_zero("rst_rdwait");
        bus.vg_req = 1'b0;
        exp_drop = 0;
        repeat (3) @(posedge clk);
        #4 rst_n = 1'b1;
        repeat (6) tick();
        chk("rst_rd_dropped", ack_cnt, ack0);
        bus.vg_req = 1'b1;
        wait_ack("post_rst", 4);
        chk("post_rst_data", bus.vg_data, 8'hA5);
        bus.vg_req = 1'b0;
        tick();

        // Randomized rounds.
        for (int r = 0; r < 20; r++) begin
            int n;
            int rdo;
            bit do_rd;
            logic [15:0] ra [12];
            logic [7:0]  rd [12];
            logic [7:0]  rexp;
            n = $urandom_range(1, 12);
            for (int i = 0; i < n; i++) begin
                case ($urandom_range(0, 4))
                    0:       ra[i] = 16'($urandom_range(0, 'h1FFF));
                    1:       ra[i] = 16'($urandom_range('h4000, 'hFFFF));
                    default: ra[i] = 16'h2000 + 16'($urandom_range(0, 'h1FFF));
                endcase
                rd[i] = 8'($urandom);
            end
            do_rd = ($urandom_range(0, 3) != 0) && (known_list.size() > 0);
            rdo = 0;
            rexp = '0;
            if (do_rd) begin
                rdo = known_list[$urandom_range(0, known_list.size() - 1)];
                for (int i = 0; i < n; i++) begin
                    if (ra[i] >= 16'h2000 && ra[i] < 16'h4000 && int'(ra[i]) - 'h2000 == rdo)
                        do_rd = 1'b0;
                end
                rexp = mdl_mem[rdo];
            end
            for (int i = 0; i < n; i++) push(ra[i], rd[i]);
            repeat ($urandom_range(0, 4)) tick();
            if (do_rd) begin
                bus.vg_addr = 13'(rdo);
                bus.vg_req  = 1'b1;
                wait_ack($sformatf("rnd%0d", r), BURST_MAX + 4);
                chk($sformatf("rnd%0d_rd_data", r), bus.vg_data, rexp);
                bus.vg_req = 1'b0;
                tick();
                chk($sformatf("rnd%0d_ack_pulse", r), bus.vg_ack, 0);
            end
            drain($sformatf("rnd%0d", r), 100);
            check_writes($sformatf("rnd%0d", r));
            chk($sformatf("rnd%0d_drop", r), bus.drop_count, exp_drop);
        end

        // Drop counter saturation.
        for (int i = 0; i < 300; i++) begin
            push(16'h4000 + 16'($urandom_range(0, 'hBFFF)), 8'($urandom));
        end
        drain("sat", 1000);
        chk("sat_drop", bus.drop_count, exp_drop);
        chk("sat_drop_ff", bus.drop_count, 8'hFF);
        check_writes("sat");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
